counter_4bit: RTL and testbench
===============================

COUNTER_4BIT -- requirements
Module: counter_4bit

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; WIDTH >= 1 SHALL be supported.
REQ-002 Parameter RESET_VAL, default 0: value loaded into q on reset; SHALL fit in WIDTH bits.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port q, output, WIDTH: current count, driven directly from a register.
REQ-006 Port tc, output, 1: terminal count; high exactly when q equals all-ones (15 at default width).

Function
REQ-007 While rst_n=0, q SHALL equal RESET_VAL (0 by default), regardless of clk.
REQ-008 On each rising clk edge with rst_n=1, q SHALL become q+1, computed modulo 2^WIDTH.
- Latency: one edge per increment.
- No enable, load or direction control.
REQ-009 Wrap-around: when q is all-ones (15), the next rising edge SHALL produce 0 with no stall or extra cycle.
REQ-010 tc SHALL be combinational from q with no register stage.
- tc=1 during the cycle in which q=15, otherwise 0.
- tc=0 during reset when RESET_VAL is not all-ones.
REQ-011 The first rising edge after rst_n deasserts SHALL increment from RESET_VAL.
- Example: with default parameters, q goes 0 -> 1 on that edge.
REQ-012 Reset mid-count: asserting rst_n=0 at any point SHALL force q to RESET_VAL immediately, without waiting for a clock edge.
- Counting SHALL resume from RESET_VAL after release.
REQ-013 Simultaneous events: if rst_n is low at a rising clk edge, reset SHALL win and q SHALL remain RESET_VAL.
REQ-014 q SHALL never be X or Z after the first reset assertion.
- No internal state SHALL exist other than the count register.

Reset
REQ-015 Reset SHALL be asynchronous on assertion: the count register is sensitive to the falling edge of rst_n.
REQ-016 Reset deassertion SHALL take effect at the next rising clk edge.
- Integrators SHALL deassert rst_n synchronously to clk; no on-chip reset synchronizer is required in this block.
REQ-017 Every register in the block SHALL be covered by rst_n.
- Reset value of q: RESET_VAL.
- Reset value of tc: derived combinationally from q.

Structure
REQ-018 A shared package counter_pkg SHALL hold:
- the default width constant (4);
- the default reset-value constant (0);
- a function computing the all-ones terminal value for a given width.
REQ-019 The block SHALL be a single flat module with one count register and the tc compare; no sub-module is required.

Verification
REQ-020 Reset hold: rst_n=0 for 12 time units with a 10-unit clock (first rising edge at t=5) -> q=0 throughout, tc=0.
REQ-021 Count: release rst_n at t=12 -> q=1 at t=15, q=2 at t=25, ..., q=10 at t=105.
REQ-022 Wrap: 16 consecutive edges after release -> q sequence 1..15 then 0; tc=1 only while q=15.
REQ-023 Async reset mid-count: with q=10, drive rst_n=0 at t=112 (between edges) -> q=0 at t=112 with no clock edge; q holds 0 through the edge at t=115.
REQ-024 Resume: release rst_n at t=122 -> q=1 at t=125, q=5 at t=165.
REQ-025 Parameter sweep: WIDTH=3, RESET_VAL=5 -> q=5 in reset, then 6, 7, 0, 1 on successive edges; tc=1 at q=7.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the free-running counter.
//   DEFAULT_WIDTH     : default counter width (4)
//   DEFAULT_RESET_VAL : default value loaded on reset (0)
//   all_ones(w)       : terminal (all-ones) value for a w-bit counter
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 4;
  localparam int unsigned DEFAULT_RESET_VAL = 0;

  // Widths up to 32 are covered. At w == 32 the shift yields 0, and
  // subtracting 1 still wraps to all-ones.
  function automatic logic [31:0] all_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_4bit.sv
// counter_4bit
//   Free-running up-counter that wraps modulo 2^WIDTH. There is no enable,
//   load or direction control.
//   Parameters:
//     WIDTH     : counter width in bits (>= 1)
//     RESET_VAL : value q takes while rst_n is low
//   Ports:
//     clk   in  : rising-edge clock
//     rst_n in  : asynchronous active-low reset
//     q     out : current count, driven straight from the count register
//     tc    out : terminal count, combinational, high while q is all-ones
module counter_4bit
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned RESET_VAL = DEFAULT_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] TERM  = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] q_q, q_d;

  // The add truncates to WIDTH bits, so all-ones rolls over to 0 on the
  // next edge with no special-case logic.
  always_comb begin
    q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_Q;
    else        q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = (q_q == TERM);

endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit
//   Two instances are exercised: the default 4-bit counter and a 3-bit
//   counter with reset value 5.
//   The stimulus process drives the resets and pushes the hand-computed
//   expected (q, tc) pairs into per-instance queues. Monitors pop and compare
//   on each falling clock edge, and on an explicit sample event that checks
//   the asynchronous reset between edges.
module tb_counter_4bit;

  typedef struct {
    string       name;
    int unsigned q;
    bit          tc;
  } exp_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       rst2_n = 1'b1;
  logic [3:0] qa;
  logic       tca;
  logic [2:0] qb;
  logic       tcb;

  exp_t qa_exp[$];
  exp_t qb_exp[$];
  int   vectors     = 0;
  int   miscompares = 0;
  event async_ev;

  // 10-unit clock with the first rising edge at t=5.
  always #5 clk = ~clk;

  counter_4bit u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (qa),
    .tc    (tca)
  );

  counter_4bit #(.WIDTH(3), .RESET_VAL(5)) u_dut_b (
    .clk   (clk),
    .rst_n (rst2_n),
    .q     (qb),
    .tc    (tcb)
  );

  task automatic push_a(input string nm, input int unsigned qv, input bit tcv);
    exp_t e;
    e.name = nm;
    e.q    = qv;
    e.tc   = tcv;
    qa_exp.push_back(e);
  endtask

  task automatic push_b(input string nm, input int unsigned qv, input bit tcv);
    exp_t e;
    e.name = nm;
    e.q    = qv;
    e.tc   = tcv;
    qb_exp.push_back(e);
  endtask

  // Monitor for the default-width instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or async_ev);
      if (qa_exp.size() != 0) begin
        e = qa_exp.pop_front();
        vectors++;
        if (int'(qa) != e.q || tca !== e.tc) begin
          miscompares++;
          $display("FAIL %s @%0t: got q=%0d tc=%0b, expected q=%0d tc=%0b",
                   e.name, $time, qa, tca, e.q, e.tc);
        end
      end
    end
  end

  // Monitor for the 3-bit, reset-value-5 instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qb_exp.size() != 0) begin
        e = qb_exp.pop_front();
        vectors++;
        if (int'(qb) != e.q || tcb !== e.tc) begin
          miscompares++;
          $display("FAIL %s @%0t: got q=%0d tc=%0b, expected q=%0d tc=%0b",
                   e.name, $time, qb, tcb, e.q, e.tc);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    rst2_n = 1'b0;

    // Default instance, sampled at the falling edges t=10..110. The sample
    // at t=10 falls inside reset (q=0). After release at t=12, the rising
    // edge at t=15 gives q=1, so the sample at t=10k+10 sees q=k.
    push_a("a_reset_hold", 0, 1'b0);
    for (int k = 1; k <= 10; k++) push_a($sformatf("a_count_%0d", k), k, 1'b0);

    // Width 3, reset value 5. Samples at t=10..50 see 5 (in reset), then
    // 6, 7 (terminal count), 0 (wrap), 1.
    push_b("b_reset_val", 5, 1'b0);
    push_b("b_count_6",   6, 1'b0);
    push_b("b_tc_7",      7, 1'b1);
    push_b("b_wrap_0",    0, 1'b0);
    push_b("b_count_1",   1, 1'b0);

    #12;
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // t=112: assert reset between edges while q=10. q must drop at once.
    #100;
    rst_n = 1'b0;
    #1;
    push_a("a_async_reset", 0, 1'b0);
    -> async_ev;
    // The rising edge at t=115 occurs with reset still low, so q holds 0.
    push_a("a_reset_wins_edge", 0, 1'b0);

    // t=122: release. The edge at t=125 gives q=1, and so on to 15 at
    // t=265 (tc high), then 0 at t=275 and 1 at t=285.
    #9;
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++)
      push_a($sformatf("a_resume_%0d", k), k, (k == 15));
    push_a("a_wrap_0", 0, 1'b0);
    push_a("a_wrap_1", 1, 1'b0);

    // Wait for both queues to drain, with a bound.
    n = 0;
    while ((qa_exp.size() != 0 || qb_exp.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (qa_exp.size() != 0 || qb_exp.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0",
               qa_exp.size() + qb_exp.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
